uart_program_loader: RTL and testbench

Serial boot loader for the virtual RISC-V device. It receives a framed program image on `uart_rx` (8N1, LSB first) and writes each 32-bit word into instruction/data memory through a ready-handshaked write port. It asserts `loading_complete`, which holds the CPU in reset until the image is in place. It sits between the device's `uart_rx` pin and the memory write mux.

---
 rtl/uart_program_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Serial boot loader: receives a 5A/len/payload/xor-checksum image on an 8N1 UART
// line and writes each little-endian 32-bit word through a ready-handshaked port.
module uart_program_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        loading_complete,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic [2:0] {
    F_WAIT_MAGIC, F_LEN0, F_LEN1, F_DATA, F_CSUM, F_DONE, F_ERROR
  } frame_state_t;

  // Write port handshake: a write is offered while mem_we is high, with
  // mem_addr/mem_wdata held stable, and completes on the first rising edge
  // where mem_we && mem_ready; mem_we drops the following cycle.

  logic rx_meta, rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  byte_state_t   byte_state, byte_state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          byte_valid, frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_state <= B_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else begin
      byte_state <= byte_state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
    end
  end

  always_comb begin
    byte_state_nxt = byte_state;
    cnt_nxt        = cnt + 1'b1;
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    byte_valid     = 1'b0;
    frame_err      = 1'b0;
    unique case (byte_state)
      B_IDLE: begin
        cnt_nxt = '0;
        // The cycle spent noticing the low level counts toward the half bit.
        if (!rx_sync) begin
          byte_state_nxt = B_START;
          cnt_nxt        = CW'(1);
        end
      end
      B_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt        = '0;
          bit_idx_nxt    = '0;
          byte_state_nxt = rx_sync ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_sync, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) byte_state_nxt = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          byte_state_nxt = B_IDLE;
          if (rx_sync) byte_valid = 1'b1;
          else         frame_err  = 1'b1;
        end
      end
      default: byte_state_nxt = B_IDLE;
    endcase
  end

  frame_state_t frame_state, frame_state_nxt;
  logic [15:0]  len, len_nxt;
  logic [15:0]  word_idx, word_idx_nxt;
  logic [1:0]   byte_idx, byte_idx_nxt;
  logic [23:0]  word_buf, word_buf_nxt;
  logic [7:0]   csum, csum_nxt;
  logic         mem_we_nxt;
  logic [31:0]  mem_addr_nxt, mem_wdata_nxt;
  logic [15:0]  words_loaded_nxt;
  logic         pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state  <= F_WAIT_MAGIC;
      len          <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      frame_state  <= frame_state_nxt;
      len          <= len_nxt;
      word_idx     <= word_idx_nxt;
      byte_idx     <= byte_idx_nxt;
      word_buf     <= word_buf_nxt;
      csum         <= csum_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      words_loaded <= words_loaded_nxt;
    end
  end

  // A write accepted on this very edge no longer counts as pending.
  assign pending = mem_we && !mem_ready;

  always_comb begin
    frame_state_nxt  = frame_state;
    len_nxt          = len;
    word_idx_nxt     = word_idx;
    byte_idx_nxt     = byte_idx;
    word_buf_nxt     = word_buf;
    csum_nxt         = csum;
    mem_we_nxt       = mem_we;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    words_loaded_nxt = words_loaded;
    if (mem_we && mem_ready) begin
      mem_we_nxt = 1'b0;
      if (words_loaded != 16'hFFFF) words_loaded_nxt = words_loaded + 16'd1;
    end
    if (frame_state != F_DONE && frame_state != F_ERROR) begin
      if (frame_err || (byte_valid && pending)) begin
        frame_state_nxt = F_ERROR;
      end else if (byte_valid) begin
        unique case (frame_state)
          F_WAIT_MAGIC: if (shreg == 8'h5A) frame_state_nxt = F_LEN0;
          F_LEN0: begin
            len_nxt[7:0]    = shreg;
            frame_state_nxt = F_LEN1;
          end
          F_LEN1: begin
            len_nxt         = {shreg, len[7:0]};
            word_idx_nxt    = '0;
            byte_idx_nxt    = '0;
            csum_nxt        = '0;
            frame_state_nxt = ({shreg, len[7:0]} == 16'd0) ? F_CSUM : F_DATA;
          end
          F_DATA: begin
            csum_nxt     = csum ^ shreg;
            byte_idx_nxt = byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_buf_nxt[7:0]   = shreg;
              2'd1: word_buf_nxt[15:8]  = shreg;
              2'd2: word_buf_nxt[23:16] = shreg;
              default: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = BASE_ADDR + {14'd0, word_idx, 2'b00};
                mem_wdata_nxt = {shreg, word_buf};
                word_idx_nxt  = word_idx + 16'd1;
                if (word_idx == len - 16'd1) frame_state_nxt = F_CSUM;
              end
            endcase
          end
          F_CSUM: frame_state_nxt = (shreg == csum) ? F_DONE : F_ERROR;
          default: frame_state_nxt = frame_state;
        endcase
      end
    end
  end

  assign loading_complete = (frame_state == F_DONE);
  assign load_error       = (frame_state == F_ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: UART byte driver, image-level reference model
// feeding an expected-write queue, and a monitor that checks every accepted write.
module tb_uart_program_loader;

  localparam int          CPB  = 8;
  localparam logic [31:0] BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        loading_complete, load_error;
  logic [15:0] words_loaded;

  int          ready_mode;  // 0 high, 1 low, 2 random
  int          n_checks, n_fail;
  logic [63:0] exp_q[$];
  logic [31:0] img_q[$];

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr, prev_data;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .loading_complete(loading_complete),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'b0;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected write for word i of an image, from the address rule alone.
  function automatic logic [63:0] model_write(input int i, input logic [31:0] w);
    logic [31:0] a;
    a = BASE + 32'(i * 4);
    return {a, w};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend)
        check("hold_stable", {31'd0, mem_we, mem_addr}, {31'd0, 1'b1, prev_addr});
      if (prev_pend)
        check("hold_data", {32'd0, mem_wdata}, {32'd0, prev_data});
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h:%0h expected none", mem_addr, mem_wdata);
        end else begin
          check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
      end
      prev_pend = mem_we && !mem_ready;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(2);
  endtask

  // Sends magic, length and img_q; checksum is the XOR of all payload bytes.
  task automatic send_image(input bit bad_csum, input bit expect_wr);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n;
    cs = 8'h00;
    n  = 16'(img_q.size());
    send_byte(8'h5A, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int i = 0; i < img_q.size(); i++) begin
      w = img_q[i];
      if (expect_wr) exp_q.push_back(model_write(i, w));
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], 1'b1);
      end
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, 1'b1);
  endtask

  task automatic check_status(input string tag, input logic lc, input logic le, input logic [15:0] wl);
    @(negedge clk);
    check({tag, "_complete"}, 64'(loading_complete), 64'(lc));
    check({tag, "_error"}, 64'(load_error), 64'(le));
    check({tag, "_words"}, 64'(words_loaded), 64'(wl));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_complete"}, 64'(loading_complete), 64'd0);
    check({tag, "_error"}, 64'(load_error), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    uart_rx    = 1'b1;
    ready_mode = 0;
    tick(3);
    exp_q.delete();
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic load_case1;
    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'h0000_006F);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         n;
    n_checks   = 0;
    n_fail     = 0;
    ready_mode = 0;
    rst_n      = 1'b0;
    uart_rx    = 1'b1;
    tick(2);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Reference two-word image.
    load_case1();
    send_image(1'b0, 1'b1);
    tick(3);
    check_status("case1", 1'b1, 1'b0, 16'd2);

    // Random images with junk before magic and random write back-pressure.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      ready_mode = 2;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h5A) b = 8'hA5;
        send_byte(b, 1'b1);
      end
      img_q.delete();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) img_q.push_back($urandom);
      send_image(1'b0, 1'b1);
      tick(5);
      ready_mode = 0;
      tick(5);
      check_status("random", 1'b1, 1'b0, 16'(n));
    end

    // Empty image after junk bytes.
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    img_q.delete();
    send_image(1'b0, 1'b1);
    tick(3);
    check_status("empty", 1'b1, 1'b0, 16'd0);

    // Bad checksum: writes still land, then error; later traffic is ignored.
    do_reset();
    load_case1();
    send_image(1'b1, 1'b1);
    tick(3);
    check_status("badcsum", 1'b0, 1'b1, 16'd2);
    send_image(1'b0, 1'b0);
    tick(3);
    check_status("after_err", 1'b0, 1'b1, 16'd2);

    // Framing error on the first length byte.
    do_reset();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h02, 1'b0);
    tick(3);
    check_status("framing", 1'b0, 1'b1, 16'd0);

    // Short glitch on idle line, then a normal image must still load.
    do_reset();
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(100);
    check_status("glitch", 1'b0, 1'b0, 16'd0);
    load_case1();
    send_image(1'b0, 1'b1);
    tick(3);
    check_status("post_glitch", 1'b1, 1'b0, 16'd2);

    // Long stall on word 0 without overrun.
    do_reset();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    ready_mode = 1;
    exp_q.push_back(model_write(0, 32'h13));
    send_byte(8'h13, 1'b1);
    for (int j = 0; j < 3; j++) send_byte(8'h00, 1'b1);
    tick(5);
    check("stall_we_early", 64'(mem_we), 64'd1);
    tick(200);
    check("stall_we_late", 64'(mem_we), 64'd1);
    check("stall_words", 64'(words_loaded), 64'd0);
    ready_mode = 0;
    for (int c = 0; c < 20 && mem_we; c++) @(negedge clk);
    check("stall_released", 64'(mem_we), 64'd0);
    check("stall_words_after", 64'(words_loaded), 64'd1);
    tick(1);
    exp_q.push_back(model_write(1, 32'h6F));
    send_byte(8'h6F, 1'b1);
    for (int j = 0; j < 3; j++) send_byte(8'h00, 1'b1);
    send_byte(8'h7C, 1'b1);
    tick(3);
    check_status("stall", 1'b1, 1'b0, 16'd2);

    // Overrun: checksum arrives while the only write is still pending.
    do_reset();
    img_q.delete();
    img_q.push_back($urandom);
    ready_mode = 1;
    send_image(1'b0, 1'b1);
    tick(5);
    check("overrun_error", 64'(load_error), 64'd1);
    check("overrun_complete", 64'(loading_complete), 64'd0);
    check("overrun_we_held", 64'(mem_we), 64'd1);
    ready_mode = 0;
    tick(10);
    check_status("overrun", 1'b0, 1'b1, 16'd1);

    // Reset in the middle of word 1, then a full reload.
    do_reset();
    exp_q.push_back(model_write(0, 32'h13));
    send_byte(8'h5A, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    for (int j = 0; j < 3; j++) send_byte(8'h00, 1'b1);
    send_byte(8'h6F, 1'b1);
    send_byte(8'h00, 1'b1);
    check("midreset_words_before", 64'(words_loaded), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    tick(3);
    exp_q.delete();
    rst_n = 1'b1;
    tick(2);
    load_case1();
    send_image(1'b0, 1'b1);
    tick(3);
    check_status("reload", 1'b1, 1'b0, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
